imem_prefetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the single-cycle core's instruction port.
- Runs a fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents the head entry to the core.
- Supports a redirect (branch/jump target) that flushes the queue and restarts fetch, discarding any stale in-flight response.

---
 rtl/imem_prefetch_queue_if.sv | 26 ++
 rtl/imem_prefetch_queue.sv | 97 +++++++++
 2 files changed

// File: rtl/imem_prefetch_queue_if.sv
// Instruction-fetch bundle: core-facing fetch/redirect signals plus the IMEM req/ack port.
// master = prefetch queue, slave = core + memory environment.
interface imem_prefetch_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  deq;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    input  redirect, redirect_pc, deq, mem_ack, mem_rdata,
    output instr_valid, instr, instr_pc, mem_req, mem_addr
  );

  modport slave (
    output redirect, redirect_pc, deq, mem_ack, mem_rdata,
    input  instr_valid, instr, instr_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_prefetch_queue.sv
// Fetch front end: one outstanding IMEM read, words queued with their PCs; head visible same cycle.
// A request is only raised when its response is guaranteed a slot; redirect flushes and drops stale acks.
module imem_prefetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           count;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic                  mem_req_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic                  drop;

  logic [31:0]           data_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q   [DEPTH];

  logic                  ack;
  logic                  push;
  logic                  pop;
  logic [AW:0]           count_next;
  logic                  space;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] redir_pc;

  always_comb begin
    ack        = mem_req_q & bus.mem_ack;
    push       = ack & ~drop;
    pop        = bus.deq & (count != '0);
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    space      = count_next < (AW+1)'(DEPTH);
    pc_next    = push ? fetch_pc + DATA_WIDTH'(4) : fetch_pc;
    redir_pc   = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fetch_pc   <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      drop       <= 1'b0;
    end else if (bus.redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= redir_pc;
      if (!mem_req_q || ack) begin
        // Nothing left in flight: restart fetch at the target immediately.
        mem_req_q  <= 1'b1;
        mem_addr_q <= redir_pc;
        drop       <= 1'b0;
      end else begin
        drop <= 1'b1;
      end
    end else begin
      count <= count_next;
      if (ack)
        drop <= 1'b0;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= pc_next;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // An unanswered request must hold address and valid until its ack.
      if (!mem_req_q || ack) begin
        mem_req_q  <= space;
        mem_addr_q <= space ? pc_next : mem_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.redirect && rst_n) begin
      data_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]   <= fetch_pc;
    end
  end

  always_comb begin
    bus.instr_valid = (count != '0);
    bus.instr       = bus.instr_valid ? data_q[rd_ptr] : '0;
    bus.instr_pc    = bus.instr_valid ? pc_q[rd_ptr] : '0;
    bus.mem_req     = mem_req_q;
    bus.mem_addr    = mem_addr_q;
  end
endmodule
